// File: rtl/vending_machine_change.sv
// rtl/vending_machine_change.sv - coin vending controller with vend pulse, dime/nickel change and saturating sales count
// Optional refund input guarded by VEND_CANCEL_EN.
module vending_machine_change #(
  parameter int PRICE    = 25,
  parameter int CREDIT_W = 8,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
`ifdef VEND_CANCEL_EN
  input  logic                cancel,
`endif
  output logic                valid,
  output logic                change_dime,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [COUNT_W-1:0]  sold_cnt
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(25);

  state_t              state, state_next;
  logic [CREDIT_W-1:0] credit_next;
  logic [CREDIT_W-1:0] coin_value;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] change_value;
  logic [COUNT_W-1:0]  sold_next;
  logic                reject_next;
  logic [1:0]          coin_count;
  logic                cancel_req;

`ifdef VEND_CANCEL_EN
  assign cancel_req = cancel && (state == COLLECT);
`else
  assign cancel_req = 1'b0;
`endif

  assign coin_count   = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
  assign coin_value   = quarter ? QUARTER_C : (dime ? DIME_C : (nickel ? NICKEL_C : '0));
  assign credit_sum   = credit + coin_value;
  assign change_value = (credit >= DIME_C) ? DIME_C : NICKEL_C;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      sold_cnt    <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_next;
      credit      <= credit_next;
      sold_cnt    <= sold_next;
      coin_reject <= reject_next;
    end
  end

  always_comb begin
    state_next  = state;
    credit_next = credit;
    sold_next   = sold_cnt;
    reject_next = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        // A refund request outranks any coin offered in the same cycle
        if (cancel_req) begin
          state_next  = CHANGE;
          reject_next = (coin_count != 2'd0);
        end else if (coin_count == 2'd1) begin
          credit_next = credit_sum;
          state_next  = (credit_sum >= PRICE_C) ? VEND : COLLECT;
        end else begin
          reject_next = (coin_count > 2'd1);
        end
      end
      VEND: begin
        reject_next = (coin_count != 2'd0);
        credit_next = credit - PRICE_C;
        sold_next   = (&sold_cnt) ? sold_cnt : sold_cnt + COUNT_W'(1);
        state_next  = (credit == PRICE_C) ? IDLE : CHANGE;
      end
      CHANGE: begin
        reject_next = (coin_count != 2'd0);
        credit_next = credit - change_value;
        state_next  = (credit == change_value) ? IDLE : CHANGE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from registered state and credit only
  assign valid         = (state == VEND);
  assign busy          = (state == VEND) || (state == CHANGE);
  assign change_dime   = (state == CHANGE) && (credit >= DIME_C);
  assign change_nickel = (state == CHANGE) && (credit < DIME_C);

endmodule

// File: tb/tb_vending_machine_change.sv
// tb/tb_vending_machine_change.sv - randomized bench for vending_machine_change against a plan-queue reference model
module tb_vending_machine_change;

  localparam int PRICE    = 25;
  localparam int CREDIT_W = 8;
  localparam int COUNT_W  = 2;
`ifdef VEND_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset, nickel, dime, quarter, cancel;
  logic                valid, change_dime, change_nickel, coin_reject, busy;
  logic [CREDIT_W-1:0] credit;
  logic [COUNT_W-1:0]  sold_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: credit, sales count and a plan of upcoming busy cycles
  // (0 = vend cycle, 10 = dime returned, 5 = nickel returned).
  int credit_m;
  int sold_m;
  bit reject_m;
  int plan[$];

  vending_machine_change #(.PRICE(PRICE), .CREDIT_W(CREDIT_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset), .nickel(nickel), .dime(dime), .quarter(quarter),
`ifdef VEND_CANCEL_EN
    .cancel(cancel),
`endif
    .valid(valid), .change_dime(change_dime), .change_nickel(change_nickel),
    .coin_reject(coin_reject), .busy(busy), .credit(credit), .sold_cnt(sold_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_change(input int amount);
    int r;
    r = amount;
    while (r >= 10) begin plan.push_back(10); r -= 10; end
    if (r == 5) plan.push_back(5);
  endtask

  task automatic model_reset();
    credit_m = 0; sold_m = 0; reject_m = 0;
    plan.delete();
  endtask

  task automatic model_edge(input bit n, input bit d, input bit q, input bit c, input bit r);
    int ncoins, val, act;
    if (r) begin model_reset(); return; end
    ncoins = int'(n) + int'(d) + int'(q);
    val    = q ? 25 : (d ? 10 : (n ? 5 : 0));
    if (plan.size() > 0) begin
      act = plan.pop_front();
      if (act == 0) begin
        credit_m -= PRICE;
        if (sold_m < (1 << COUNT_W) - 1) sold_m++;
      end else begin
        credit_m -= act;
      end
      reject_m = (ncoins > 0);
    end else if (CANCEL_EN && c && credit_m > 0) begin
      push_change(credit_m);
      reject_m = (ncoins > 0);
    end else if (ncoins == 1) begin
      credit_m += val;
      reject_m = 0;
      if (credit_m >= PRICE) begin
        plan.push_back(0);
        push_change(credit_m - PRICE);
      end
    end else begin
      reject_m = (ncoins > 1);
    end
  endtask

  task automatic compare_outputs();
    int head;
    head = (plan.size() > 0) ? plan[0] : -1;
    check("valid",         valid,         head == 0);
    check("change_dime",   change_dime,   head == 10);
    check("change_nickel", change_nickel, head == 5);
    check("busy",          busy,          plan.size() > 0);
    check("coin_reject",   coin_reject,   reject_m);
    check("credit",        credit,        credit_m);
    check("sold_cnt",      sold_cnt,      sold_m);
  endtask

  task automatic step(input bit n, input bit d, input bit q, input bit c, input bit r);
    @(negedge clk);
    compare_outputs();
    nickel = n; dime = d; quarter = q; cancel = c; reset = r;
    @(posedge clk);
    model_edge(n, d, q, c, r);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    step(0, 0, 0, 0, 1);
    idle(1);

    step(0, 0, 1, 0, 0); idle(3);
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); idle(4);
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 0, 1, 0, 0);
    idle(1); step(1, 0, 0, 0, 0); idle(3);
    step(1, 1, 0, 0, 0); idle(2);
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 0, 1, 0, 0);
    idle(2); step(0, 0, 0, 0, 1); idle(3);
    step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(0, 0, 0, 1, 0); idle(4);
    step(0, 1, 0, 0, 0); step(1, 0, 0, 1, 0); idle(4);
    for (int i = 0; i < 4; i++) begin step(0, 0, 1, 0, 0); idle(2); end

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(4) == 0,
           $urandom_range(9) == 0, $urandom_range(149) == 0);
    end
    @(negedge clk);
    compare_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
